// File: rtl/multiboot_pkg.sv
// Shared types and constants for the multiboot request front end.
package multiboot_pkg;

  // Request FSM states; encodings are exported on state_dbg.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLatch    = 3'd1,
    StReq      = 3'd2,
    StWaitAck  = 3'd3,
    StWaitDone = 3'd4,
    StHoldoff  = 3'd5
  } boot_state_e;

  // Default warm-boot image locations in SPI flash; image 0 is the golden image.
  localparam logic [23:0] ImgAddr0 = 24'h000000;
  localparam logic [23:0] ImgAddr1 = 24'h340000;
  localparam logic [23:0] ImgAddr2 = 24'h680000;
  localparam logic [23:0] ImgAddr3 = 24'h9C0000;

  // SPI read opcodes: plain read and fast read.
  localparam logic [7:0] OpcRead     = 8'h03;
  localparam logic [7:0] OpcFastRead = 8'h0B;

endpackage

// File: rtl/key_debounce.sv
// Push-button synchroniser and debouncer producing one pulse per accepted press.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter logic        KEY_ACTIVE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic key_flag_o
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic            deb_prev_q;
  logic            flag_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press;

  // Two-stage synchroniser; idles at the released level so reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= ~KEY_ACTIVE;
      sync2_q <= ~KEY_ACTIVE;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Count how long the synchronised key has disagreed with the debounced level.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CntLast) begin
      // Stable long enough: adopt the new level. The >= also keeps the count from wrapping.
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign press = (deb_q == KEY_ACTIVE) && (deb_prev_q != KEY_ACTIVE);

  // Debounced level, its previous value and the registered press pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      deb_q      <= ~KEY_ACTIVE;
      deb_prev_q <= ~KEY_ACTIVE;
      flag_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      flag_q     <= press;
    end
  end

  assign key_flag_o = flag_q;

endmodule

// File: rtl/boot_req_gen.sv
// Multiboot request generator: debounced press -> latched image address -> supervised boot request.
module boot_req_gen
  import multiboot_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 1_000_000,
  parameter int unsigned ACK_TIMEOUT    = 64,
  parameter int unsigned HOLDOFF_CYCLES = 4096,
  parameter logic        KEY_ACTIVE     = 1'b0,
  parameter logic [23:0] IMG0_ADDR      = ImgAddr0,
  parameter logic [23:0] IMG1_ADDR      = ImgAddr1,
  parameter logic [23:0] IMG2_ADDR      = ImgAddr2,
  parameter logic [23:0] IMG3_ADDR      = ImgAddr3,
  parameter logic [7:0]  RD_OPCODE      = OpcFastRead
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        key_in,
  input  logic [1:0]  img_sel,
  input  logic        seq_busy,
  output logic        key_flag,
  output logic        boot_req,
  output logic [23:0] boot_addr,
  output logic [7:0]  boot_opcode,
  output logic        req_err,
  output logic [2:0]  state_dbg
);

  localparam int unsigned CntMax  = (ACK_TIMEOUT > HOLDOFF_CYCLES) ? ACK_TIMEOUT : HOLDOFF_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] AckLast  = CntW'(ACK_TIMEOUT - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLDOFF_CYCLES - 1);

  boot_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [23:0]     addr_q, addr_d;
  logic [7:0]      opc_q, opc_d;
  logic [1:0]      sel1_q, sel2_q;
  logic [23:0]     sel_addr;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .KEY_ACTIVE (KEY_ACTIVE)
  ) u_key_debounce (
    .clk_i      (sclk),
    .rst_ni     (rst_n),
    .key_i      (key_in),
    .key_flag_o (key_flag)
  );

  // Two-stage synchroniser for the quasi-static image switches.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sel1_q <= 2'b00;
      sel2_q <= 2'b00;
    end else begin
      sel1_q <= img_sel;
      sel2_q <= sel1_q;
    end
  end

  // Map the synchronised switch setting to its flash image address.
  always_comb begin
    sel_addr = IMG0_ADDR;
    unique case (sel2_q)
      2'd0: sel_addr = IMG0_ADDR;
      2'd1: sel_addr = IMG1_ADDR;
      2'd2: sel_addr = IMG2_ADDR;
      2'd3: sel_addr = IMG3_ADDR;
      default: sel_addr = IMG0_ADDR;
    endcase
  end

  // Request sequencing: next state, counter, latched address and pulse outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    opc_d    = opc_q;
    boot_req = 1'b0;
    req_err  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_flag) state_d = StLatch;
      end
      StLatch: begin
        addr_d  = sel_addr;
        opc_d   = RD_OPCODE;
        state_d = StReq;
      end
      StReq: begin
        boot_req = 1'b1;
        cnt_d    = '0;
        state_d  = StWaitAck;
      end
      StWaitAck: begin
        if (seq_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q >= AckLast) begin
          req_err = 1'b1;
          cnt_d   = CntW'(1);
          state_d = StHoldoff;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        // The cycle that ends the run already counts as the first dead cycle.
        if (!seq_busy) begin
          cnt_d   = CntW'(1);
          state_d = StHoldoff;
        end
      end
      StHoldoff: begin
        if (cnt_q >= HoldLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, shared timeout/hold-off counter and the presented boot target.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= IMG0_ADDR;
      opc_q   <= RD_OPCODE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      opc_q   <= opc_d;
    end
  end

  assign boot_addr   = addr_q;
  assign boot_opcode = opc_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_boot_req_gen.sv
// Directed self-checking bench for boot_req_gen with shortened timing parameters.
module tb_boot_req_gen;

  logic        sclk;
  logic        rst_n;
  logic        key_in;
  logic [1:0]  img_sel;
  logic        seq_busy;
  logic        key_flag;
  logic        boot_req;
  logic [23:0] boot_addr;
  logic [7:0]  boot_opcode;
  logic        req_err;
  logic [2:0]  state_dbg;

  int checks;
  int failures;
  int flag_cnt;
  int req_cnt;
  int err_cnt;
  int f0, r0, e0;

  boot_req_gen #(
    .DEB_CYCLES     (8),
    .ACK_TIMEOUT    (4),
    .HOLDOFF_CYCLES (16)
  ) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .img_sel     (img_sel),
    .seq_busy    (seq_busy),
    .key_flag    (key_flag),
    .boot_req    (boot_req),
    .boot_addr   (boot_addr),
    .boot_opcode (boot_opcode),
    .req_err     (req_err),
    .state_dbg   (state_dbg)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  // Pulse counters sampled on the falling edge.
  initial begin
    flag_cnt = 0;
    req_cnt  = 0;
    err_cnt  = 0;
    forever begin
      @(negedge sclk);
      if (rst_n) begin
        if (key_flag) flag_cnt++;
        if (boot_req) req_cnt++;
        if (req_err)  err_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic snap();
    f0 = flag_cnt;
    r0 = req_cnt;
    e0 = err_cnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_in = 1'b1; img_sel = 2'b00; seq_busy = 1'b0;
    step_n(3);
    checks++; if (key_flag !== 1'b0) begin failures++; $display("FAIL rst_key_flag got=%0b want=0", key_flag); end
    checks++; if (boot_req !== 1'b0) begin failures++; $display("FAIL rst_boot_req got=%0b want=0", boot_req); end
    checks++; if (req_err !== 1'b0) begin failures++; $display("FAIL rst_req_err got=%0b want=0", req_err); end
    checks++; if (boot_addr !== 24'h000000) begin failures++; $display("FAIL rst_addr got=%h want=000000", boot_addr); end
    checks++; if (boot_opcode !== 8'h0B) begin failures++; $display("FAIL rst_opcode got=%h want=0b", boot_opcode); end
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d want=0", state_dbg); end
    rst_n = 1'b1;
    step_n(15);
  endtask

  task automatic test_clean_press();
    img_sel = 2'b01;
    step_n(4);
    snap();
    key_in = 1'b0;
    step_n(10);
    checks++; if (key_flag !== 1'b0) begin failures++; $display("FAIL clean_flag_early got=%0b want=0", key_flag); end
    step();
    checks++; if (key_flag !== 1'b1) begin failures++; $display("FAIL clean_flag_at11 got=%0b want=1", key_flag); end
    step();
    checks++; if (state_dbg !== 3'd1) begin failures++; $display("FAIL clean_latch got=%0d want=1", state_dbg); end
    step();
    checks++; if (boot_req !== 1'b1) begin failures++; $display("FAIL clean_req got=%0b want=1", boot_req); end
    checks++; if (boot_addr !== 24'h340000) begin failures++; $display("FAIL clean_addr got=%h want=340000", boot_addr); end
    checks++; if (boot_opcode !== 8'h0B) begin failures++; $display("FAIL clean_opcode got=%h want=0b", boot_opcode); end
    step();
    checks++; if (state_dbg !== 3'd3 || boot_req !== 1'b0) begin failures++; $display("FAIL clean_wait_ack state=%0d req=%0b want 3/0", state_dbg, boot_req); end
    step();
    seq_busy = 1'b1;
    step();
    checks++; if (state_dbg !== 3'd4) begin failures++; $display("FAIL clean_wait_done got=%0d want=4", state_dbg); end
    step_n(9);
    seq_busy = 1'b0;
    step();
    checks++; if (state_dbg !== 3'd5) begin failures++; $display("FAIL clean_holdoff got=%0d want=5", state_dbg); end
    step_n(14);
    checks++; if (state_dbg !== 3'd5) begin failures++; $display("FAIL clean_holdoff_end got=%0d want=5", state_dbg); end
    step();
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL clean_idle got=%0d want=0", state_dbg); end
    key_in = 1'b1;
    step_n(15);
    checks++; if (flag_cnt - f0 !== 1 || req_cnt - r0 !== 1 || err_cnt - e0 !== 0) begin
      failures++; $display("FAIL clean_counts flags=%0d reqs=%0d errs=%0d want 1/1/0", flag_cnt - f0, req_cnt - r0, err_cnt - e0);
    end
  endtask

  task automatic test_bounce();
    snap();
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) key_in = ~key_in;
      step();
    end
    checks++; if (flag_cnt - f0 !== 0) begin failures++; $display("FAIL bounce_quiet flags=%0d want=0", flag_cnt - f0); end
    key_in = 1'b0;
    step_n(11);
    checks++; if (key_flag !== 1'b1) begin failures++; $display("FAIL bounce_flag got=%0b want=1", key_flag); end
    step_n(2);
    checks++; if (boot_req !== 1'b1) begin failures++; $display("FAIL bounce_req got=%0b want=1", boot_req); end
    step();
    seq_busy = 1'b1;
    step_n(3);
    seq_busy = 1'b0;
    step_n(20);
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL bounce_idle got=%0d want=0", state_dbg); end
    checks++; if (flag_cnt - f0 !== 1 || req_cnt - r0 !== 1) begin
      failures++; $display("FAIL bounce_counts flags=%0d reqs=%0d want 1/1", flag_cnt - f0, req_cnt - r0);
    end
    key_in = 1'b1;
    step_n(15);
  endtask

  task automatic test_timeout();
    img_sel = 2'b10;
    step_n(4);
    snap();
    key_in = 1'b0;
    step_n(13);
    checks++; if (boot_req !== 1'b1 || boot_addr !== 24'h680000) begin
      failures++; $display("FAIL tmo_req req=%0b addr=%h want 1/680000", boot_req, boot_addr);
    end
    step_n(3);
    checks++; if (req_err !== 1'b0 || state_dbg !== 3'd3) begin
      failures++; $display("FAIL tmo_early err=%0b state=%0d want 0/3", req_err, state_dbg);
    end
    step();
    checks++; if (req_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%0b want=1", req_err); end
    step();
    checks++; if (state_dbg !== 3'd5 || req_err !== 1'b0) begin
      failures++; $display("FAIL tmo_holdoff state=%0d err=%0b want 5/0", state_dbg, req_err);
    end
    step_n(14);
    checks++; if (state_dbg !== 3'd5) begin failures++; $display("FAIL tmo_holdoff_end got=%0d want=5", state_dbg); end
    step();
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL tmo_idle got=%0d want=0", state_dbg); end
    step_n(20);
    checks++; if (req_cnt - r0 !== 1 || err_cnt - e0 !== 1) begin
      failures++; $display("FAIL tmo_counts reqs=%0d errs=%0d want 1/1", req_cnt - r0, err_cnt - e0);
    end
    key_in = 1'b1;
    step_n(15);
  endtask

  task automatic test_second_press();
    img_sel = 2'b01;
    step_n(4);
    snap();
    key_in = 1'b0;
    step_n(13);
    checks++; if (boot_req !== 1'b1) begin failures++; $display("FAIL second_req got=%0b want=1", boot_req); end
    step();
    img_sel  = 2'b11;
    seq_busy = 1'b1;
    step_n(2);
    checks++; if (state_dbg !== 3'd4) begin failures++; $display("FAIL second_wait_done got=%0d want=4", state_dbg); end
    key_in = 1'b1;
    step_n(15);
    key_in = 1'b0;
    step_n(11);
    checks++; if (key_flag !== 1'b1 || state_dbg !== 3'd4) begin
      failures++; $display("FAIL second_flag flag=%0b state=%0d want 1/4", key_flag, state_dbg);
    end
    step_n(5);
    checks++; if (boot_addr !== 24'h340000) begin failures++; $display("FAIL second_addr_busy got=%h want=340000", boot_addr); end
    seq_busy = 1'b0;
    step_n(20);
    checks++; if (state_dbg !== 3'd0 || boot_addr !== 24'h340000) begin
      failures++; $display("FAIL second_end state=%0d addr=%h want 0/340000", state_dbg, boot_addr);
    end
    checks++; if (flag_cnt - f0 !== 2 || req_cnt - r0 !== 1) begin
      failures++; $display("FAIL second_counts flags=%0d reqs=%0d want 2/1", flag_cnt - f0, req_cnt - r0);
    end
    key_in = 1'b1;
    step_n(15);
  endtask

  task automatic test_reset_mid();
    img_sel = 2'b10;
    step_n(4);
    key_in = 1'b0;
    step_n(13);
    step();
    seq_busy = 1'b1;
    step_n(2);
    checks++; if (state_dbg !== 3'd4 || boot_addr !== 24'h680000) begin
      failures++; $display("FAIL rmid_pre state=%0d addr=%h want 4/680000", state_dbg, boot_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL rmid_state got=%0d want=0", state_dbg); end
    checks++; if (boot_addr !== 24'h000000 || boot_opcode !== 8'h0B) begin
      failures++; $display("FAIL rmid_addr addr=%h opc=%h want 000000/0b", boot_addr, boot_opcode);
    end
    checks++; if (boot_req !== 1'b0 || req_err !== 1'b0 || key_flag !== 1'b0) begin
      failures++; $display("FAIL rmid_pulses req=%0b err=%0b flag=%0b want 0/0/0", boot_req, req_err, key_flag);
    end
    key_in = 1'b1; seq_busy = 1'b0; img_sel = 2'b00;
    step_n(3);
    rst_n = 1'b1;
    step_n(4);
    snap();
    key_in = 1'b0;
    step_n(11);
    checks++; if (key_flag !== 1'b1) begin failures++; $display("FAIL rmid_flag got=%0b want=1", key_flag); end
    step_n(2);
    checks++; if (boot_req !== 1'b1 || boot_addr !== 24'h000000) begin
      failures++; $display("FAIL rmid_req req=%0b addr=%h want 1/000000", boot_req, boot_addr);
    end
    step_n(25);
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL rmid_idle got=%0d want=0", state_dbg); end
    key_in = 1'b1;
    step_n(15);
  endtask

  task automatic test_long_hold();
    snap();
    key_in = 1'b0;
    step_n(1000);
    checks++; if (flag_cnt - f0 !== 1 || req_cnt - r0 !== 1 || err_cnt - e0 !== 1) begin
      failures++; $display("FAIL hold_counts flags=%0d reqs=%0d errs=%0d want 1/1/1", flag_cnt - f0, req_cnt - r0, err_cnt - e0);
    end
    key_in = 1'b1;
    step_n(30);
    checks++; if (flag_cnt - f0 !== 1 || state_dbg !== 3'd0) begin
      failures++; $display("FAIL hold_release flags=%0d state=%0d want 1/0", flag_cnt - f0, state_dbg);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_timeout();
    test_second_press();
    test_reset_mid();
    test_long_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
